// File: rtl/register_file.sv
// MIPS general-purpose register file: one decoded write port, two combinational
// read ports with write-first bypass, register 0 hardwired to zero.
module register_file #(
    parameter int width      = 32,
    parameter int addr_width = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [width-1:0]      wr_data,
    input  logic [addr_width-1:0] rd_addr0,
    input  logic [addr_width-1:0] rd_addr1,
    output logic [width-1:0]      rd_data0,
    output logic [width-1:0]      rd_data1
);

    localparam int depth = 2 ** addr_width;

    logic [width-1:0] regs_r [depth];
    logic [depth-1:0] wr_sel_s;
    logic             wr_live_s;

    // A write only counts when enabled, not in reset and not aimed at r0
    assign wr_live_s = wr_en && !rst && (wr_addr != {addr_width{1'b0}});

    // One-hot write-enable demux
    always_comb begin
        wr_sel_s = {depth{1'b0}};
        if (wr_live_s) begin
            wr_sel_s[wr_addr] = 1'b1;
        end else begin
            wr_sel_s = {depth{1'b0}};
        end
    end

    // Register storage; reset wins over a same-cycle write, r0 held at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                regs_r[i] <= {width{1'b0}};
            end
        end else begin
            regs_r[0] <= {width{1'b0}};
            for (int i = 1; i < depth; i++) begin
                if (wr_sel_s[i]) begin
                    regs_r[i] <= wr_data;
                end
            end
        end
    end

    // Read port 0: zero in reset or for r0, write-first bypass, else stored value
    always_comb begin
        rd_data0 = {width{1'b0}};
        if (rst || (rd_addr0 == {addr_width{1'b0}})) begin
            rd_data0 = {width{1'b0}};
        end else if (wr_live_s && (rd_addr0 == wr_addr)) begin
            rd_data0 = wr_data;
        end else begin
            rd_data0 = regs_r[rd_addr0];
        end
    end

    // Read port 1: same rules as port 0 so equal addresses give equal data
    always_comb begin
        rd_data1 = {width{1'b0}};
        if (rst || (rd_addr1 == {addr_width{1'b0}})) begin
            rd_data1 = {width{1'b0}};
        end else if (wr_live_s && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = regs_r[rd_addr1];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read data is queued per cycle
// from a reference array and compared mid-cycle against both read ports.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;

    typedef struct {
        string       tag;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    register_file #(.width(32), .addr_width(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expect_read(input logic r, input logic we, input logic [4:0] wa,
                                                input logic [31:0] wd, input logic [4:0] ra);
        if (r || ra == 5'd0) return 32'h0;
        if (we && wa != 5'd0 && wa == ra) return wd;
        return model[ra];
    endfunction

    // Drive one cycle, queue the expectation, compare at negedge, then update the model
    task automatic cycle(input string tag, input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t e;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr0 = ra0; rd_addr1 = ra1;
        e.tag  = tag;
        e.exp0 = expect_read(r, we, wa, wd, ra0);
        e.exp1 = expect_read(r, we, wa, wd, ra1);
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got 1 expected 0", tag);
        end else begin
            e = sb_q.pop_front();
            check_value({e.tag, "_rd0"}, rd_data0, e.exp0);
            check_value({e.tag, "_rd1"}, rd_data1, e.exp1);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; rd_addr0 = 5'd0; rd_addr1 = 5'd0;
        @(posedge clk);
        #1;
        cycle("reset", 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        cycle("after_reset", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);

        cycle("wr_r5", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd4);
        cycle("rd_r5", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        cycle("rst_r5", 1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        cycle("rd_r5_cleared", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

        cycle("wr_r0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        cycle("rd_r0", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        cycle("wr_r8", 1'b0, 1'b1, 5'd8, 32'h12345678, 5'd1, 5'd2);
        cycle("rd_r8_r9", 1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9);

        cycle("wr_r10", 1'b0, 1'b1, 5'd10, 32'h00000001, 5'd10, 5'd0);
        cycle("bypass_r10", 1'b0, 1'b1, 5'd10, 32'hCAFEF00D, 5'd10, 5'd10);
        cycle("rd_r10", 1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);

        cycle("rst_wr_r3", 1'b1, 1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3);
        cycle("rd_r3", 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        cycle("wr_r3_post", 1'b0, 1'b1, 5'd3, 32'h0F0F0F0F, 5'd0, 5'd3);
        cycle("rd_r3_post", 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);

        for (int i = 1; i < 32; i++) begin
            cycle("sweep_wr", 1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i - 1), 5'(i));
        end
        for (int i = 0; i < 32; i++) begin
            cycle("sweep_rd", 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        end

        for (int n = 0; n < 300; n++) begin
            cycle("random", ($urandom_range(0, 40) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
        end

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
